// File: rtl/constant_stream_source.sv
// Emits the constant word VALUE as a counted valid/ready stream, with count_in words per start command.
// Optional feature: define CONSTANT_STREAM_ABORT_EN to add an abort input that ends a run early.
module constant_stream_source #(
    parameter int                    WORD_WIDTH  = 8,
    parameter logic [WORD_WIDTH-1:0] VALUE       = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic                   busy,
    output logic                   done,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_data,
    output logic                   output_last
`ifdef CONSTANT_STREAM_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] counter;
    logic                   xfer;
    logic                   last_beat;
    logic                   end_run;

    assign xfer      = output_valid && output_ready;
    assign last_beat = (counter == COUNT_WIDTH'(1));

`ifdef CONSTANT_STREAM_ABORT_EN
    // An abort still lets a same-cycle transfer complete; the run simply stops after it.
    assign end_run = (xfer && last_beat) || abort;
`else
    assign end_run = xfer && last_beat;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every output is a flop
    // and the clear branch, tested first, overrides every other input in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= IDLE;
            counter      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            output_valid <= 1'b0;
            output_data  <= '0;
            output_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_in != '0) begin
                            state        <= RUN;
                            counter      <= count_in;
                            busy         <= 1'b1;
                            output_valid <= 1'b1;
                            output_data  <= VALUE;
                            output_last  <= (count_in == COUNT_WIDTH'(1));
                        end else begin
                            // Zero-length run: acknowledge with done but emit nothing.
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (end_run) begin
                        state        <= IDLE;
                        counter      <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        output_valid <= 1'b0;
                        output_data  <= '0;
                        output_last  <= 1'b0;
                    end else if (xfer) begin
                        // counter >= 2 here, so the decrement can never wrap.
                        counter     <= counter - COUNT_WIDTH'(1);
                        output_last <= (counter == COUNT_WIDTH'(2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_constant_stream_source.sv
// Self-checking bench for constant_stream_source: directed scenarios plus random traffic,
// compared every cycle against a words-remaining reference model.
`timescale 1ns/1ps
module tb_constant_stream_source;

    localparam int         WW  = 8;
    localparam int         CW  = 16;
    localparam logic [7:0] VAL = 8'hA5;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [CW-1:0] count_in;
    logic          busy;
    logic          done;
    logic          output_valid;
    logic          output_ready;
    logic [WW-1:0] output_data;
    logic          output_last;
`ifdef CONSTANT_STREAM_ABORT_EN
    logic          abort;
`endif

    constant_stream_source #(
        .WORD_WIDTH (WW),
        .VALUE      (VAL),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .count_in    (count_in),
        .busy        (busy),
        .done        (done),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_data (output_data),
        .output_last (output_last)
`ifdef CONSTANT_STREAM_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: words still owed in the current run, and whether done is due.
    int rem    = 0;
    bit done_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string ctx);
        bit v;
        v = (rem > 0);
        check({ctx, ":busy"},  32'(busy),         32'(v));
        check({ctx, ":done"},  32'(done),         32'(done_e));
        check({ctx, ":valid"}, 32'(output_valid), 32'(v));
        check({ctx, ":data"},  32'(output_data),  v ? 32'(VAL) : 32'd0);
        check({ctx, ":last"},  32'(output_last),  32'(rem == 1));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input string ctx, input bit clr, input bit st, input int cnt,
                        input bit rdy, input bit ab);
        clear        = clr;
        start        = st;
        count_in     = CW'(cnt);
        output_ready = rdy;
`ifdef CONSTANT_STREAM_ABORT_EN
        abort        = ab;
`endif
        @(posedge clock);
        if (clr) begin
            rem    = 0;
            done_e = 1'b0;
        end else if (rem > 0) begin
            done_e = 1'b0;
            if (rdy) begin
                rem--;
                if (rem == 0) done_e = 1'b1;
            end
`ifdef CONSTANT_STREAM_ABORT_EN
            if (ab && rem > 0) begin
                rem    = 0;
                done_e = 1'b1;
            end
`endif
        end else begin
            done_e = st && (cnt == 0);
            if (st && cnt != 0) rem = cnt;
        end
        @(negedge clock);
        compare(ctx);
    endtask

    initial begin
        clear        = 1'b1;
        start        = 1'b0;
        count_in     = '0;
        output_ready = 1'b0;
`ifdef CONSTANT_STREAM_ABORT_EN
        abort        = 1'b0;
`endif
        step("reset", 1, 0, 0, 0, 0);
        step("reset_start", 1, 1, 5, 1, 0);
        step("idle", 0, 0, 0, 1, 0);

        // Basic run of three words with ready held high.
        step("basic_start", 0, 1, 3, 1, 0);
        for (int i = 0; i < 4; i++) step("basic", 0, 0, 0, 1, 0);

        // Backpressure: ready pattern 1,0,0,1,1,0,1 must yield exactly four transfers.
        step("bp_start", 0, 1, 4, 0, 0);
        begin
            bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
            for (int i = 0; i < 7; i++) step("bp", 0, 0, 0, pat[i], 0);
        end
        step("bp_tail", 0, 0, 0, 1, 0);

        // Zero count: done next cycle, nothing emitted.
        step("zero_start", 0, 1, 0, 1, 0);
        step("zero_after", 0, 0, 0, 1, 0);

        // Start while busy is ignored; then back-to-back start in the done cycle.
        step("busy_start", 0, 1, 2, 1, 0);
        step("busy_restart", 0, 1, 9, 1, 0);
        step("busy_final", 0, 1, 9, 1, 0);
        step("b2b_start", 0, 1, 1, 0, 0);
        step("b2b_stall", 0, 0, 0, 0, 0);
        step("b2b_beat", 0, 0, 0, 1, 0);
        step("b2b_idle", 0, 0, 0, 1, 0);

        // Clear mid-run drops the run without done; a fresh run works afterwards.
        step("clr_start", 0, 1, 5, 1, 0);
        step("clr_beat", 0, 0, 0, 1, 0);
        step("clr_beat", 0, 0, 0, 1, 0);
        step("clr_hit", 1, 0, 0, 1, 0);
        step("clr_idle", 0, 0, 0, 1, 0);
        step("clr_restart", 0, 1, 2, 1, 0);
        for (int i = 0; i < 3; i++) step("clr_run", 0, 0, 0, 1, 0);

`ifdef CONSTANT_STREAM_ABORT_EN
        // Abort coinciding with the fourth transfer of a ten-word run.
        step("abort_start", 0, 1, 10, 1, 0);
        for (int i = 0; i < 3; i++) step("abort_run", 0, 0, 0, 1, 0);
        step("abort_hit", 0, 0, 0, 1, 1);
        step("abort_idle", 0, 0, 0, 1, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
